// File: rtl/vector_sequencer.sv
// Stimulus/check engine: replays {stimulus, expected} vectors from a small
// memory into a combinational DUT and scores its responses.
module vector_sequencer #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 4,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2,
  parameter int SETTLE = 1,
  parameter int CNT_W  = 8,
  parameter int LOOP   = 0
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_en,
  input  logic [ADDR_W-1:0]      load_addr,
  input  logic [IN_W+OUT_W-1:0]  load_data,
  input  logic [ADDR_W:0]        vec_count,
  input  logic                   start,
  input  logic                   stop,
  output logic [IN_W-1:0]        dut_in,
  input  logic [OUT_W-1:0]       dut_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [CNT_W-1:0]       err_count,
  output logic [ADDR_W-1:0]      first_err
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam int                HOLD_W    = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(SETTLE - 1);
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

  state_t              state_q, state_d;
  logic [IN_W-1:0]     dut_in_q, dut_in_d;
  logic [ADDR_W-1:0]   index_q, index_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [CNT_W-1:0]    err_q, err_d;
  logic [ADDR_W-1:0]   first_q, first_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;

  logic [IN_W+OUT_W-1:0] mem_q [DEPTH];

  logic last_vec;
  logic mismatch;

  assign last_vec = ({1'b0, index_q} == (cnt_q - (ADDR_W + 1)'(1)));
  assign mismatch = (dut_out != mem_q[index_q][OUT_W-1:0]);

  // NOTE: vector memory has no reset; contents must survive a reset so a
  // harness can rerun without reloading.
  always_ff @(posedge clk) begin
    if (load_en && state_q != S_RUN) begin
      mem_q[load_addr] <= load_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      dut_in_q <= '0;
      index_q  <= '0;
      hold_q   <= '0;
      err_q    <= '0;
      first_q  <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dut_in_q <= dut_in_d;
      index_q  <= index_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: every next-state signal gets its hold value first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    dut_in_d = dut_in_q;
    index_d  = index_q;
    hold_d   = hold_q;
    err_d    = err_q;
    first_d  = first_q;
    cnt_d    = cnt_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          err_d   = '0;
          first_d = '0;
          if (vec_count == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_d    = (vec_count > DEPTH_CNT) ? DEPTH_CNT : vec_count;
            index_d  = '0;
            hold_d   = '0;
            dut_in_d = mem_q[0][IN_W+OUT_W-1:OUT_W];
            state_d  = S_RUN;
          end
        end
      end

      S_RUN: begin
        // stop wins over a sample edge; the current vector is not scored
        if (stop) begin
          state_d = S_DONE;
        end else if (hold_q != HOLD_LAST) begin
          hold_d = hold_q + HOLD_W'(1);
        end else begin
          hold_d = '0;
          if (mismatch) begin
            if (err_q == '0) first_d = index_q;
            if (err_q != '1) err_d = err_q + CNT_W'(1);
          end
          if (last_vec) begin
            if (LOOP != 0) begin
              index_d  = '0;
              dut_in_d = mem_q[0][IN_W+OUT_W-1:OUT_W];
            end else begin
              state_d = S_DONE;
            end
          end else begin
            index_d  = index_q + ADDR_W'(1);
            dut_in_d = mem_q[index_q + ADDR_W'(1)][IN_W+OUT_W-1:OUT_W];
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign dut_in    = dut_in_q;
  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == '0);
  assign err_count = err_q;
  assign first_err = first_q;

endmodule

// File: doc/vector_sequencer.md
Name: vector_sequencer

Overview:
Parametrised, synthesizable stimulus/check engine for combinational blocks such as decoders and ALU slices. It holds a vector memory of {stimulus, expected} pairs loaded through a write port, drives each stimulus to a DUT, and compares the DUT response against the expected value. It counts mismatches, records the first failing index, and reports pass/done. Optional loop mode re-runs the vector set until it is stopped. The block sits beside the DUT in on-board and simulation test harnesses.

Parameters:
IN_W, 2, stimulus width (DUT input)
OUT_W, 4, expected/response width (DUT output)
DEPTH, 4, number of vector entries (power of two, >=2)
ADDR_W, 2, log2(DEPTH)
SETTLE, 1, cycles each stimulus is held before sampling (>=1)
CNT_W, 8, error counter width
LOOP, 0, 1 = wrap to vector 0 after the last vector and keep running

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
load_en  in  1  write vector memory this cycle
load_addr  in  ADDR_W  write index
load_data  in  IN_W+OUT_W  {stimulus[IN_W-1:0], expected[OUT_W-1:0]}, stimulus in the upper bits
vec_count  in  ADDR_W+1  number of vectors to run (0..DEPTH), sampled at start
start  in  1  begin a run (level sampled, one pulse sufficient)
stop  in  1  abort the run
dut_in  out  IN_W  registered stimulus to the DUT
dut_out  in  OUT_W  DUT response
busy  out  1  run in progress
done  out  1  run finished
pass  out  1  done and zero errors
err_count  out  CNT_W  mismatches this run, saturating
first_err  out  ADDR_W  index of first mismatch (valid when err_count != 0)

Behaviour:
- Reset (async, any state): state=IDLE; dut_in=0, busy=0, done=0, pass=0, err_count=0, first_err=0, index=0, hold counter=0. Memory contents are not cleared by reset.
- Memory: a write occurs on a rising edge with load_en=1, only while in IDLE or DONE. Writes during RUN are ignored.
- FSM states: IDLE, RUN, DONE.
- IDLE/DONE with start=1:
  - If vec_count=0: go to DONE at that edge with err_count=0 and pass=1.
  - Otherwise: latch vec_count, set index=0, dut_in=mem[0].stim, hold=0, clear err_count/first_err/done/pass, busy=1, and go to RUN.
- start while in RUN is ignored.
- RUN, each edge:
  - If hold < SETTLE-1: hold++.
  - Otherwise (sample edge): compare dut_out with mem[index].exp.
    - On mismatch: err_count++ (saturate at 2^CNT_W-1). If this is the first mismatch, first_err=index.
    - Then, if index = vec_count-1:
      - LOOP=0: go to DONE, busy=0, done=1, pass=(final err_count==0).
      - LOOP=1: index=0, dut_in=mem[0].stim, hold=0, stay in RUN; err_count keeps accumulating.
    - Else: index++, dut_in=mem[index+1].stim, hold=0.
- Latency: vector k is driven at edge 1+k*SETTLE after start and sampled SETTLE edges later. A full run takes vec_count*SETTLE cycles from the start edge to done.
- stop=1 in RUN: go to DONE at the next edge without checking the current vector; pass is computed from errors so far. stop has priority over the sample edge. stop in IDLE/DONE has no effect.
- DONE holds all outputs and dut_in stable until the next start or reset.
- The index wraps only via the vec_count compare. vec_count > DEPTH is clamped to DEPTH.
- The DUT must be combinational with settle time < SETTLE cycles.

Test Plan:
- Load a 2-to-4 decoder set {00,0001},{01,0010},{10,0100},{11,1000}, vec_count=4, SETTLE=1, correct DUT -> dut_in steps 00,01,10,11 on consecutive edges; done=1 four cycles after start; err_count=0; pass=1.
- Same vectors with a DUT stuck at output 0001 -> err_count=3, first_err=1, pass=0, done=1.
- vec_count=0, then start -> done=1 and pass=1 on the next edge; dut_in unchanged; busy stays 0.
- LOOP=1, correct DUT, run 10 cycles, then stop -> dut_in cycles 00,01,10,11,00,...; done at the edge after stop; err_count=0.
- SETTLE=3, assert reset mid-run at cycle 5 -> all outputs return to 0 immediately (asynchronously); a subsequent start without reloading replays the same vectors, proving memory is retained.
- load_en pulses during RUN with different data -> run results are unchanged; a rerun afterwards shows the original vectors.
